// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out stage that sits after the 4-bit PIPO register.
//   A parallel word is accepted over a valid/ready handshake into a one-word
//   hold buffer. The buffer feeds a shift register, so a word that is already
//   waiting is reloaded on the same edge the previous word's last bit retires.
//   This gives gapless back-to-back serialization at one word per WIDTH cycles.
//
// Parameters
//   WIDTH      parallel word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   pin         parallel data word
//   pin_valid   pin holds a word to transfer
//   pin_ready   hold buffer is empty; a word can be accepted this cycle
//   sout        serial data bit (0 when not shifting)
//   sout_valid  sout carries a data bit this cycle
//   sout_last   sout is the final bit of the current word
//   busy        a word is being shifted or is waiting in the hold buffer
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  input  logic             pin_valid,
  output logic             pin_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_hbuf;
  logic             r_hfull;
  logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
  logic [CNT_W-1:0] r_cnt,  w_cnt_nxt;

  logic             w_accept;
  logic             w_load;
  logic             w_cnt_last;
  logic             w_shifting;
  logic [WIDTH-1:0] w_sreg_shifted;

  // Ready depends only on the buffer flag, never on pin_valid, so an
  // upstream source can wait on it without forming a combinational loop.
  assign pin_ready  = ~r_hfull;
  assign w_accept   = pin_valid & ~r_hfull;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_shifting = (r_state == SHIFT);

  // Move the next bit into the output position, zero-filling behind it.
  assign w_sreg_shifted = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0}
                                    : {1'b0, r_sreg[WIDTH-1:1]};

  // Next-state / datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_hfull) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!w_cnt_last) begin
          w_sreg_nxt = w_sreg_shifted;
          w_cnt_nxt  = r_cnt + 1'b1;
        end else if (r_hfull) begin
          // Reload on the last-bit edge: no idle bubble between words.
          w_load = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_load) begin
      w_sreg_nxt = r_hbuf;
      w_cnt_nxt  = '0;
    end
  end

  // Accept and transfer are mutually exclusive: accept needs an empty
  // buffer, transfer needs a full one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_hbuf  <= '0;
      r_hfull <= 1'b0;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_hbuf  <= pin;
        r_hfull <= 1'b1;
      end else if (w_load) begin
        r_hfull <= 1'b0;
      end
    end
  end

  assign sout       = w_shifting & (MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0]);
  assign sout_valid = w_shifting;
  assign sout_last  = w_shifting & w_cnt_last;
  assign busy       = w_shifting | r_hfull;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Three serializers (W4 MSB-first, W4 LSB-first, W8 LSB-first) are driven
//   in lockstep. Each has a reference model that tracks "bits of the current
//   word still to be sent" and "one word parked", derived from the handshake
//   and framing rules, and every cycle all outputs are checked against it.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] pv;
  logic [7:0] pw [3];
  logic [2:0] pr, so, sv, sl, bz;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .pin(pw[0][3:0]), .pin_valid(pv[0]), .pin_ready(pr[0]),
    .sout(so[0]), .sout_valid(sv[0]), .sout_last(sl[0]), .busy(bz[0]));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst), .pin(pw[1][3:0]), .pin_valid(pv[1]), .pin_ready(pr[1]),
    .sout(so[1]), .sout_valid(sv[1]), .sout_last(sl[1]), .busy(bz[1]));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .pin(pw[2]), .pin_valid(pv[2]), .pin_ready(pr[2]),
    .sout(so[2]), .sout_valid(sv[2]), .sout_last(sl[2]), .busy(bz[2]));

  int W   [3] = '{4, 4, 8};
  bit MSB [3] = '{1'b1, 1'b0, 1'b0};

  // source word lists: src[k][sh..sn-1] still to be delivered
  logic [7:0] src [3][64];
  int         sn  [3];
  int         sh  [3];

  // reference model: mseq holds remaining bits of the current word in send
  // order (bit 0 is on the wire), mrem counts them; mheld/mhw is the park slot
  logic [7:0] mseq  [3];
  int         mrem  [3];
  logic       mheld [3];
  logic [7:0] mhw   [3];

  int ncmp = 0;
  int nmis = 0;

  function automatic logic [7:0] order(int k, logic [7:0] word);
    logic [7:0] o = '0;
    for (int i = 0; i < W[k]; i++)
      o[i] = MSB[k] ? word[W[k]-1-i] : word[i];
    return o;
  endfunction

  task automatic chk(string tag, int k, logic obs, logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s[u%0d] t=%0t observed=%b expected=%b", tag, k, $time, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 3; k++) begin
      pv[k] = (sh[k] < sn[k]);
      pw[k] = pv[k] ? src[k][sh[k]] : 8'h00;
    end
  endtask

  task automatic push(int k, logic [7:0] w);
    src[k][sn[k]] = w;
    sn[k]++;
  endtask

  task automatic push3(logic [7:0] a, logic [7:0] b, logic [7:0] c);
    push(0, a); push(1, b); push(2, c);
    drive();
  endtask

  task automatic flush();
    for (int k = 0; k < 3; k++) sh[k] = sn[k];
    drive();
  endtask

  task automatic model_edge(int k);
    logic acc;
    if (!rst) begin
      mrem[k] = 0; mheld[k] = 1'b0; mseq[k] = '0;
      return;
    end
    acc = pv[k] && !mheld[k];
    if (mrem[k] > 0) begin
      mseq[k] = mseq[k] >> 1;
      mrem[k]--;
    end
    if (mheld[k] && mrem[k] == 0) begin
      mseq[k]  = order(k, mhw[k]);
      mrem[k]  = W[k];
      mheld[k] = 1'b0;
    end
    if (acc) begin
      mheld[k] = 1'b1;
      mhw[k]   = pw[k];
      sh[k]++;
    end
  endtask

  // check outputs mid-cycle, advance the model across the edge, re-drive
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("pin_ready",  k, pr[k], !mheld[k]);
      chk("busy",       k, bz[k], (mrem[k] > 0) || mheld[k]);
      chk("sout_valid", k, sv[k], mrem[k] > 0);
      chk("sout_last",  k, sl[k], mrem[k] == 1);
      chk("sout",       k, so[k], (mrem[k] > 0) ? mseq[k][0] : 1'b0);
    end
    for (int k = 0; k < 3; k++) model_edge(k);
    @(posedge clk); #1;
    drive();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      sn[k] = 0; sh[k] = 0; mseq[k] = '0; mrem[k] = 0;
      mheld[k] = 1'b0; mhw[k] = '0;
    end

    // reset with a word presented: must be ignored
    rst = 1'b0;
    push3(8'h0F, 8'h0F, 8'hFF);
    @(posedge clk); #1;
    run(2);
    rst = 1'b1;
    flush();
    run(2);

    // single word
    push3(8'h0B, 8'h0B, 8'hA5);
    run(12);

    // back-to-back pair
    push3(8'h0C, 8'h0C, 8'hC3);
    push3(8'h06, 8'h06, 8'h3C);
    run(20);

    // three words under backpressure
    push3(8'h01, 8'h01, 8'h81);
    push3(8'h08, 8'h08, 8'h18);
    push3(8'h0F, 8'h0F, 8'hFF);
    run(32);

    // reset mid-shift with a second word parked
    push3(8'h0B, 8'h0B, 8'hA5);
    push3(8'h06, 8'h06, 8'h66);
    run(3);
    rst = 1'b0;
    run(1);
    rst = 1'b1;
    flush();
    push3(8'h01, 8'h01, 8'h01);
    run(12);

    // randomized traffic with one asynchronous-looking reset in the middle
    for (int i = 0; i < 160; i++) begin
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 2) == 0 && (sn[k] - sh[k]) < 2 && sn[k] < 64)
          push(k, 8'($urandom));
      drive();
      if (i == 80) begin
        rst = 1'b0;
        run(1);
        rst = 1'b1;
        flush();
      end
      tick();
    end
    flush();
    run(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Downstream companion to the 4-bit PIPO register stage: takes its parallel output word and serializes it onto a single-bit stream.
- A valid/ready handshake on the parallel side, plus a one-word hold buffer, gives gapless back-to-back serialization.
- The serial side carries valid and last-bit qualifiers so a downstream consumer can frame words.

Parameters:
- WIDTH, 4, parallel word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- pin  input  WIDTH  parallel data word; typically the PIPO pout.
- pin_valid  input  1  pin holds a word to transfer.
- pin_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid data bit this cycle.
- sout_last  output  1  sout is the final bit of the current word.
- busy  output  1  a word is being shifted or is waiting in the hold buffer.

Behaviour:
- Reset (rst=0 at a rising edge):
  - State goes to IDLE; shift register, bit counter, hold buffer and hold-full flag (hfull) clear to 0.
  - Outputs: sout=0, sout_valid=0, sout_last=0, busy=0, pin_ready=1.
  - pin and pin_valid are ignored while rst=0.
- Internal storage:
  - hbuf (WIDTH) plus hfull.
  - sreg (WIDTH).
  - cnt, clog2(WIDTH) bits.
  - State: IDLE or SHIFT.
- pin_ready = ~hfull. It is combinational from the register, with no combinational path from pin_valid.
- Accept: when pin_valid && pin_ready at an edge, pin -> hbuf and hfull -> 1.
  - The source must hold pin and pin_valid stable until accepted.
  - pin_valid with pin_ready=0 has no effect.
- IDLE: if hfull=1 at an edge, then hbuf -> sreg, cnt -> 0, hfull -> 0, and the next state is SHIFT.
- SHIFT, each edge:
  - If cnt < WIDTH-1: shift sreg by one toward the output end (zero-fill) and increment cnt.
  - If cnt == WIDTH-1 and hfull=1: reload sreg from hbuf, cnt -> 0, hfull -> 0, stay in SHIFT. There is no idle bubble.
  - If cnt == WIDTH-1 and hfull=0: go to IDLE.
- Outputs:
  - sout = sreg[WIDTH-1] if MSB_FIRST, else sreg[0], qualified as 0 when not in SHIFT.
  - sout_valid = (state == SHIFT).
  - sout_last = (state == SHIFT) && (cnt == WIDTH-1).
  - busy = (state == SHIFT) || hfull.
- Latency and throughput:
  - A word accepted at edge N from IDLE with an empty buffer presents its first bit after edge N+1.
  - Its last bit appears after edge N+WIDTH.
  - Sustained throughput is one word per WIDTH cycles.
- Simultaneous accept and transfer cannot occur: pin_ready=0 whenever hfull=1. The next accept happens no earlier than the edge after the transfer.
- Reset mid-operation:
  - The partially shifted word and any buffered word are discarded.
  - No sout_last is emitted for the truncated word.
  - The next word after reset serializes from its first bit.
- No overflow condition exists: backpressure through pin_ready is the only flow control. The serial side has no ready input.

Test Plan:
- Reset: hold rst=0 for 2 edges with pin_valid=1, pin=4'b1111 -> sout=0, sout_valid=0, sout_last=0, busy=0, pin_ready=1, and no word captured.
- Single word (WIDTH=4, MSB_FIRST=1): pin=4'b1011 accepted at edge N -> sout=1,0,1,1 after edges N+1..N+4.
  - sout_valid=1 on those 4 cycles; sout_last=1 only on the 4th.
  - sout_valid=0 and busy=0 after edge N+5.
- Back-to-back: 4'b1100 then 4'b0110, with pin_valid held high -> 8 contiguous valid bits 1,1,0,0,0,1,1,0.
  - pin_ready=0 in the cycle after each accept.
  - sout_last pulses on bits 4 and 8; no gap between words.
- Backpressure: present 3 words (4'b0001, 4'b1000, 4'b1111) continuously -> each accepted exactly once, in order.
  - Serial stream is 0001 1000 1111 with no loss or duplication.
  - busy stays 1 until after the final sout_last.
- Reset mid-shift: after 2 bits of 4'b1011, with a second word buffered, drive rst=0 for one edge -> sout_valid=0, busy=0, pin_ready=1.
  - A following word 4'b0001 serializes as 0,0,0,1 with sout_last on the 4th bit.
- LSB-first (MSB_FIRST=0): pin=4'b1011 -> sout=1,1,0,1.
  - Repeat with WIDTH=8, pin=8'hA5 -> 1,0,1,0,0,1,0,1, with sout_last on the 8th bit.
